// File: rtl/bcd_conv_pkg.sv
// ---------------------------------------------------------------------------
// bcd_conv_pkg
// Shared definitions for the sequential binary-to-BCD converter:
//   - state_t     : converter FSM states (IDLE, SHIFT, DONE)
//   - bcd_digits  : number of BCD digits needed for an n-bit binary value
//   - SEG7_TABLE  : seven-segment codes, active-high, bit order gfedcba,
//                   indexed by BCD digit value (10..15 blank)
// ---------------------------------------------------------------------------
package bcd_conv_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      DONE  = 2'd2
   } state_t;

   // (n+2)/3 digits always cover 2^n-1 because each digit holds more than
   // three bits worth of range; it is not the minimum for every n.
   function automatic int bcd_digits(input int n);
      return (n + 2) / 3;
   endfunction

   // Entry 15 is the leftmost element, entry 0 the rightmost.
   localparam logic [15:0][6:0] SEG7_TABLE = {
      7'b0000000, 7'b0000000, 7'b0000000,   // 15, 14, 13
      7'b0000000, 7'b0000000, 7'b0000000,   // 12, 11, 10
      7'b1101111,                           // 9
      7'b1111111,                           // 8
      7'b0000111,                           // 7
      7'b1111101,                           // 6
      7'b1101101,                           // 5
      7'b1100110,                           // 4
      7'b1001111,                           // 3
      7'b1011011,                           // 2
      7'b0000110,                           // 1
      7'b0111111                            // 0
   };

endpackage

// File: rtl/bcd_conv_dd_adj.sv
// ---------------------------------------------------------------------------
// dd_adj
// Combinational double-dabble digit correction: adds 3 to a BCD digit when it
// is 5 or more, so that the following left shift carries into the next digit
// exactly when the doubled value reaches 10.
//   d : input digit (always 0..9 in normal use)
//   q : corrected digit, truncated to 4 bits (cannot overflow for d <= 9)
// ---------------------------------------------------------------------------
module dd_adj (
   input  logic [3:0] d,
   output logic [3:0] q
);

   always_comb begin
      q = d;
      if (d >= 4'd5) begin
         q = d + 4'd3;
      end
   end

endmodule

// File: rtl/bcd_conv.sv
// ---------------------------------------------------------------------------
// bcd_conv
// Sequential binary-to-BCD converter (shift-and-add-3). An accepted start
// captures `bin`, the value is shifted in MSB-first over N cycles, and the
// packed BCD result is published with a one-cycle `done` pulse.
//
// Ports:
//   clk   : clock, rising edge
//   rst   : synchronous, active-low reset
//   start : conversion request, honoured only in IDLE or DONE
//   bin   : N-bit binary input, captured on an accepted start
//   busy  : high while shifting
//   done  : one-cycle pulse when bcd is updated
//   bcd   : packed BCD result, digit 0 in [3:0]; holds the last result
//   count : shift steps completed in the current conversion
//   seg   : seven-segment codes per digit (only when SEG7_EN is defined)
//
// Build option: define SEG7_EN to add the registered seven-segment output.
// ---------------------------------------------------------------------------
module bcd_conv
   import bcd_conv_pkg::*;
#(
   parameter  int N      = 4,
   localparam int DIGITS = bcd_digits(N),
   localparam int CW     = $clog2(N + 1)
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  start,
   input  logic [N-1:0]          bin,
   output logic                  busy,
   output logic                  done,
   output logic [4*DIGITS-1:0]   bcd,
   output logic [CW-1:0]         count
`ifdef SEG7_EN
   ,
   output logic [7*DIGITS-1:0]   seg
`endif
);

   localparam logic [CW-1:0] LAST_STEP = CW'(N - 1);

   state_t                state_q, state_d;
   logic [N-1:0]          shreg_q, shreg_d;
   logic [4*DIGITS-1:0]   scratch_q, scratch_d;
   logic [4*DIGITS-1:0]   bcd_q, bcd_d;
   logic [CW-1:0]         count_q, count_d;

   logic [4*DIGITS-1:0]   scratch_adj;
   logic [4*DIGITS-1:0]   step_bcd;
   logic                  enter_done;

   genvar gi;
   generate
      for (gi = 0; gi < DIGITS; gi++) begin : g_adj
         dd_adj u_adj (
            .d (scratch_q[4*gi +: 4]),
            .q (scratch_adj[4*gi +: 4])
         );
      end
   endgenerate

   // Adjusted digits shift left by one, taking the next binary bit (MSB first).
   assign step_bcd   = {scratch_adj[4*DIGITS-2:0], shreg_q[N-1]};
   assign enter_done = (state_q == SHIFT) && (count_q == LAST_STEP);

   always_comb begin
      state_d   = state_q;
      shreg_d   = shreg_q;
      scratch_d = scratch_q;
      bcd_d     = bcd_q;
      count_d   = count_q;

      case (state_q)
         IDLE: begin
            if (start) begin
               state_d   = SHIFT;
               shreg_d   = bin;
               scratch_d = '0;
               count_d   = '0;
            end
         end
         SHIFT: begin
            scratch_d = step_bcd;
            shreg_d   = shreg_q << 1;
            count_d   = count_q + CW'(1);
            if (enter_done) begin
               state_d = DONE;
               bcd_d   = step_bcd;
            end
         end
         DONE: begin
            if (start) begin
               state_d   = SHIFT;
               shreg_d   = bin;
               scratch_d = '0;
               count_d   = '0;
            end else begin
               state_d = IDLE;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q   <= IDLE;
         shreg_q   <= '0;
         scratch_q <= '0;
         bcd_q     <= '0;
         count_q   <= '0;
      end else begin
         state_q   <= state_d;
         shreg_q   <= shreg_d;
         scratch_q <= scratch_d;
         bcd_q     <= bcd_d;
         count_q   <= count_d;
      end
   end

   assign busy  = (state_q == SHIFT);
   assign done  = (state_q == DONE);
   assign bcd   = bcd_q;
   assign count = count_q;

`ifdef SEG7_EN
   logic [7*DIGITS-1:0] seg_q, seg_d;
   logic [7*DIGITS-1:0] seg_dec;

   // Decode the value being written into bcd so both registers update together.
   generate
      for (gi = 0; gi < DIGITS; gi++) begin : g_seg
         assign seg_dec[7*gi +: 7] = SEG7_TABLE[step_bcd[4*gi +: 4]];
      end
   endgenerate

   always_comb begin
      seg_d = seg_q;
      if (enter_done) begin
         seg_d = seg_dec;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         seg_q <= {DIGITS{SEG7_TABLE[0]}};
      end else begin
         seg_q <= seg_d;
      end
   end

   assign seg = seg_q;
`endif

endmodule

// File: tb/tb_bcd_conv.sv
// ---------------------------------------------------------------------------
// tb_bcd_conv
// Self-checking bench for bcd_conv with two instances: N=4 (2 digits) and
// N=8 (3 digits). Expected BCD values come from decimal arithmetic on the
// input value; expected seven-segment codes from a per-digit lookup.
// ---------------------------------------------------------------------------
module tb_bcd_conv;

   logic        clk = 1'b0;
   logic        rst;
   logic        start4, start8;
   logic [3:0]  bin4;
   logic [7:0]  bin8;
   logic        busy4, done4, busy8, done8;
   logic [7:0]  bcd4;
   logic [11:0] bcd8;
   logic [2:0]  count4;
   logic [3:0]  count8;
`ifdef SEG7_EN
   logic [13:0] seg4;
   logic [20:0] seg8;
`endif

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   bcd_conv #(.N(4)) dut4 (
      .clk   (clk),
      .rst   (rst),
      .start (start4),
      .bin   (bin4),
      .busy  (busy4),
      .done  (done4),
      .bcd   (bcd4),
      .count (count4)
`ifdef SEG7_EN
      ,
      .seg   (seg4)
`endif
   );

   bcd_conv #(.N(8)) dut8 (
      .clk   (clk),
      .rst   (rst),
      .start (start8),
      .bin   (bin8),
      .busy  (busy8),
      .done  (done8),
      .bcd   (bcd8),
      .count (count8)
`ifdef SEG7_EN
      ,
      .seg   (seg8)
`endif
   );

   // ---------------- reference model ----------------
   function automatic logic [11:0] bcd_ref(input int v);
      logic [11:0] r;
      int x;
      r = '0;
      x = v;
      for (int i = 0; i < 3; i++) begin
         r[4*i +: 4] = 4'(x % 10);
         x = x / 10;
      end
      return r;
   endfunction

   function automatic logic [6:0] seg_digit(input int d);
      case (d)
         0: return 7'b0111111;
         1: return 7'b0000110;
         2: return 7'b1011011;
         3: return 7'b1001111;
         4: return 7'b1100110;
         5: return 7'b1101101;
         6: return 7'b1111101;
         7: return 7'b0000111;
         8: return 7'b1111111;
         9: return 7'b1101111;
         default: return 7'b0000000;
      endcase
   endfunction

   function automatic logic [20:0] seg_ref(input int v);
      logic [20:0] r;
      int x;
      r = '0;
      x = v;
      for (int i = 0; i < 3; i++) begin
         r[7*i +: 7] = seg_digit(x % 10);
         x = x / 10;
      end
      return r;
   endfunction

   // ---------------- drivers ----------------
   task automatic run4(input logic [3:0] v, output int lat, output logic [7:0] got,
                       output logic [2:0] cnt, output logic busy1, output logic [7:0] held);
      @(negedge clk);
      start4 = 1'b1;
      bin4   = v;
      @(negedge clk);
      start4 = 1'b0;
      bin4   = 4'($urandom);
      lat    = 1;
      busy1  = busy4;
      held   = bcd4;
      while (!done4 && lat < 40) begin
         @(negedge clk);
         lat++;
      end
      got = bcd4;
      cnt = count4;
      $display("conv n4 bin=%0d bcd=%h count=%0d latency=%0d", v, got, cnt, lat);
   endtask

   task automatic run8(input logic [7:0] v, output int lat, output logic [11:0] got,
                       output logic [3:0] cnt);
      @(negedge clk);
      start8 = 1'b1;
      bin8   = v;
      @(negedge clk);
      start8 = 1'b0;
      bin8   = 8'($urandom);
      lat    = 1;
      while (!done8 && lat < 40) begin
         @(negedge clk);
         lat++;
      end
      got = bcd8;
      cnt = count8;
      $display("conv n8 bin=%0d bcd=%h count=%0d latency=%0d", v, got, cnt, lat);
   endtask

   // ---------------- tests ----------------
   task automatic test_reset();
      rst    = 1'b0;
      start4 = 1'b0;
      start8 = 1'b0;
      bin4   = '0;
      bin8   = '0;
      repeat (3) @(negedge clk);
      checks++;
      if ({busy4, done4, bcd4, count4} !== 13'd0) begin
         errors++;
         $display("FAIL reset_n4 got busy=%b done=%b bcd=%h count=%0d want all 0",
                  busy4, done4, bcd4, count4);
      end
      checks++;
      if ({busy8, done8, bcd8, count8} !== 18'd0) begin
         errors++;
         $display("FAIL reset_n8 got busy=%b done=%b bcd=%h count=%0d want all 0",
                  busy8, done8, bcd8, count8);
      end
`ifdef SEG7_EN
      checks++;
      if (seg4 !== 14'(seg_ref(0)) || seg8 !== seg_ref(0)) begin
         errors++;
         $display("FAIL reset_seg got %b / %b want zeros shown", seg4, seg8);
      end
`endif
      @(negedge clk);
      rst = 1'b1;
      $display("reset released");
   endtask

   task automatic test_basic();
      int lat;
      logic [7:0] got, held;
      logic [2:0] cnt;
      logic b1;
      int vals[3] = '{15, 0, 9};
      foreach (vals[k]) begin
         run4(4'(vals[k]), lat, got, cnt, b1, held);
         checks++;
         if (got !== bcd_ref(vals[k]) || lat != 5 || cnt !== 3'd4 || b1 !== 1'b1) begin
            errors++;
            $display("FAIL basic bin=%0d got bcd=%h lat=%0d count=%0d busy=%b want bcd=%h lat=5 count=4 busy=1",
                     vals[k], got, lat, cnt, b1, bcd_ref(vals[k]));
         end
`ifdef SEG7_EN
         checks++;
         if (seg4 !== 14'(seg_ref(vals[k]))) begin
            errors++;
            $display("FAIL basic_seg bin=%0d got %b want %b", vals[k], seg4, 14'(seg_ref(vals[k])));
         end
`endif
      end
   endtask

   task automatic test_random4();
      int lat;
      logic [7:0] got, held, prev;
      logic [2:0] cnt;
      logic b1;
      int v;
      prev = bcd4;
      for (int k = 0; k < 16; k++) begin
         v = int'($urandom_range(0, 15));
         run4(4'(v), lat, got, cnt, b1, held);
         checks++;
         if (got !== bcd_ref(v) || lat != 5 || cnt !== 3'd4 || held !== prev) begin
            errors++;
            $display("FAIL random4 bin=%0d got bcd=%h lat=%0d count=%0d held=%h want bcd=%h lat=5 count=4 held=%h",
                     v, got, lat, cnt, held, bcd_ref(v), prev);
         end
         prev = bcd_ref(v);
      end
   endtask

   task automatic test_ignore_busy();
      int pulses = 0;
      logic [7:0] got = 8'hxx;
      @(negedge clk);
      start4 = 1'b1;
      bin4   = 4'd12;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (i < 3) begin
            start4 = 1'b1;
            bin4   = 4'd7;
         end else begin
            start4 = 1'b0;
         end
         if (done4) begin
            pulses++;
            got = bcd4;
         end
      end
      $display("conv n4 bin=12 with start during busy: pulses=%0d bcd=%h", pulses, got);
      checks++;
      if (pulses != 1 || got !== 8'h12) begin
         errors++;
         $display("FAIL ignore_busy got pulses=%0d bcd=%h want pulses=1 bcd=12", pulses, got);
      end
   endtask

   task automatic test_reset_mid();
      int pulses = 0;
      int lat;
      logic [7:0] got, held;
      logic [2:0] cnt;
      logic b1;
      @(negedge clk);
      start4 = 1'b1;
      bin4   = 4'd13;
      @(negedge clk);
      start4 = 1'b0;
      @(negedge clk);
      @(negedge clk);
      checks++;
      if (count4 !== 3'd2 || busy4 !== 1'b1) begin
         errors++;
         $display("FAIL mid_count got count=%0d busy=%b want count=2 busy=1", count4, busy4);
      end
      rst = 1'b0;
      @(negedge clk);
      rst = 1'b1;
      checks++;
      if ({busy4, done4, bcd4, count4} !== 13'd0) begin
         errors++;
         $display("FAIL mid_reset got busy=%b done=%b bcd=%h count=%0d want all 0",
                  busy4, done4, bcd4, count4);
      end
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         if (done4) pulses++;
      end
      $display("reset mid-conversion: done pulses afterwards=%0d", pulses);
      checks++;
      if (pulses != 0 || busy4 !== 1'b0) begin
         errors++;
         $display("FAIL mid_no_done got pulses=%0d busy=%b want 0 0", pulses, busy4);
      end
      run4(4'd3, lat, got, cnt, b1, held);
      checks++;
      if (got !== 8'h03 || lat != 5 || held !== 8'h00) begin
         errors++;
         $display("FAIL mid_restart got bcd=%h lat=%0d held=%h want 03 5 00", got, lat, held);
      end
   endtask

   task automatic test_back_to_back();
      int pulses = 0;
      int last = -1;
      @(negedge clk);
      start4 = 1'b1;
      bin4   = 4'd10;
      for (int i = 0; i < 30; i++) begin
         @(negedge clk);
         if (done4) begin
            pulses++;
            $display("conv n4 back-to-back bin=10 bcd=%h at cycle %0d", bcd4, i);
            checks++;
            if (bcd4 !== 8'h10 || busy4 !== 1'b0 || count4 !== 3'd4 ||
                i != ((last < 0) ? 4 : last + 5)) begin
               errors++;
               $display("FAIL b2b got bcd=%h busy=%b count=%0d cycle=%0d want 10 0 4 cycle=%0d",
                        bcd4, busy4, count4, i, (last < 0) ? 4 : last + 5);
            end
`ifdef SEG7_EN
            checks++;
            if (seg4 !== {7'b0000110, 7'b0111111}) begin
               errors++;
               $display("FAIL b2b_seg got %b want 00001100111111", seg4);
            end
`endif
            last = i;
         end
      end
      start4 = 1'b0;
      checks++;
      if (pulses != 6) begin
         errors++;
         $display("FAIL b2b_count got %0d pulses want 6", pulses);
      end
      repeat (8) @(negedge clk);
   endtask

   task automatic test_n8();
      int lat;
      logic [11:0] got;
      logic [3:0] cnt;
      int v;
      for (int k = 0; k < 12; k++) begin
         v = (k == 0) ? 255 : (k == 1) ? 100 : int'($urandom_range(0, 255));
         run8(8'(v), lat, got, cnt);
         checks++;
         if (got !== bcd_ref(v) || lat != 9 || cnt !== 4'd8) begin
            errors++;
            $display("FAIL n8 bin=%0d got bcd=%h lat=%0d count=%0d want bcd=%h lat=9 count=8",
                     v, got, lat, cnt, bcd_ref(v));
         end
`ifdef SEG7_EN
         checks++;
         if (seg8 !== seg_ref(v)) begin
            errors++;
            $display("FAIL n8_seg bin=%0d got %b want %b", v, seg8, seg_ref(v));
         end
`endif
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_random4();
      test_ignore_busy();
      test_reset_mid();
      test_back_to_back();
      test_n8();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
